// File: rtl/vdp_rd_ifce.sv
// vdp_rd_ifce -- CPU-side data/status port of the video display processor.
//
// Keeps the 14-bit VRAM pointer and a one-byte read-ahead buffer. It also runs
// a two-state fetch engine toward VRAM and keeps the status byte
// {F, 5S, C, fifth_num}.
//
// Ports
//   pxclk         pixel clock; all state changes on its rising edge
//   reset         asynchronous, active-low reset
//   rd0_tick      CPU read strobe, data port
//   rd1_tick      CPU read strobe, status port
//   wr0_tick      CPU write strobe, data port (din = byte written)
//   addr_set      pointer load pulse (addr_val = new pointer, addr_rd = read setup)
//   vram_rd_*     VRAM fetch handshake (req/addr out, ack/data in)
//   frame_tick, coinc_tick, fifth_tick, fifth_num   status event sources
//   ie / irq      interrupt enable / registered F AND ie
//   dout          byte returned to the CPU, held between reads
//   vram_addr     current pointer
//   latch_clr     pulse one cycle after any CPU data/status access
module vdp_rd_ifce (
  input  logic        pxclk,
  input  logic        reset,
  input  logic        rd0_tick,
  input  logic        rd1_tick,
  input  logic        wr0_tick,
  input  logic [7:0]  din,
  input  logic        addr_set,
  input  logic [13:0] addr_val,
  input  logic        addr_rd,
  output logic        vram_rd_req,
  output logic [13:0] vram_rd_addr,
  input  logic        vram_rd_ack,
  input  logic [7:0]  vram_rd_data,
  input  logic        frame_tick,
  input  logic        coinc_tick,
  input  logic        fifth_tick,
  input  logic [4:0]  fifth_num,
  input  logic        ie,
  output logic        irq,
  output logic [7:0]  dout,
  output logic [13:0] vram_addr,
  output logic        latch_clr
);

  typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} fetch_state_t;

  fetch_state_t state_r;
  logic [7:0]   buf_r;
  logic         stale_r;
  logic         reissue_r;
  logic         flag_f_r;
  logic         flag_5s_r;
  logic         flag_c_r;
  logic [4:0]   fnum_r;

  logic [13:0]  ptr_next_s;
  logic         start_s;
  logic         stale_next_s;
  logic         reissue_next_s;
  logic [7:0]   status_s;

  // Next pointer value, fetch trigger and in-flight bookkeeping.
  always_comb begin
    ptr_next_s     = vram_addr;
    start_s        = 1'b0;
    stale_next_s   = stale_r;
    reissue_next_s = reissue_r;
    // addr_set wins over an increment in the same cycle
    if (addr_set) begin
      ptr_next_s = addr_val;
    end else if (rd0_tick || wr0_tick) begin
      ptr_next_s = vram_addr + 14'd1;
    end else begin
      ptr_next_s = vram_addr;
    end
    start_s = (addr_set && addr_rd) || rd0_tick;
    // Any pointer or buffer activity makes the outstanding fetch useless.
    stale_next_s = stale_r || rd0_tick || addr_set || wr0_tick;
    // A write after a pending re-read cancels the re-read, since the buffer
    // now holds the written byte.
    if (rd0_tick || addr_set) begin
      reissue_next_s = 1'b1;
    end else if (wr0_tick) begin
      reissue_next_s = 1'b0;
    end else begin
      reissue_next_s = reissue_r;
    end
    status_s = {flag_f_r, flag_5s_r, flag_c_r, fnum_r};
  end

  // Fetch FSM with registered request and address.
  always_ff @(posedge pxclk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      vram_rd_req  <= 1'b0;
      vram_rd_addr <= 14'd0;
      stale_r      <= 1'b0;
      reissue_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          stale_r   <= 1'b0;
          reissue_r <= 1'b0;
          if (start_s || (reissue_r && !wr0_tick)) begin
            state_r      <= REQ;
            vram_rd_req  <= 1'b1;
            vram_rd_addr <= ptr_next_s;
          end else begin
            state_r     <= IDLE;
            vram_rd_req <= 1'b0;
          end
        end
        REQ: begin
          reissue_r <= reissue_next_s;
          if (vram_rd_ack) begin
            state_r     <= IDLE;
            vram_rd_req <= 1'b0;
            stale_r     <= 1'b0;
          end else begin
            state_r     <= REQ;
            vram_rd_req <= 1'b1;
            stale_r     <= stale_next_s;
          end
        end
        default: begin
          state_r     <= IDLE;
          vram_rd_req <= 1'b0;
          stale_r     <= 1'b0;
          reissue_r   <= 1'b0;
        end
      endcase
    end
  end

  // Pointer, read-ahead buffer, CPU output byte and latch-clear pulse.
  always_ff @(posedge pxclk or negedge reset) begin
    if (!reset) begin
      vram_addr <= 14'd0;
      buf_r     <= 8'd0;
      dout      <= 8'd0;
      latch_clr <= 1'b0;
    end else begin
      vram_addr <= ptr_next_s;
      if (wr0_tick) begin
        buf_r <= din;
      end else if ((state_r == REQ) && vram_rd_ack && !stale_next_s) begin
        buf_r <= vram_rd_data;
      end else begin
        buf_r <= buf_r;
      end
      // dout takes the buffer before any same-cycle buffer update lands
      if (rd0_tick) begin
        dout <= buf_r;
      end else if (rd1_tick) begin
        dout <= status_s;
      end else begin
        dout <= dout;
      end
      latch_clr <= rd0_tick || rd1_tick || wr0_tick;
    end
  end

  // Status flags (a set event beats a status-read clear) and interrupt.
  always_ff @(posedge pxclk or negedge reset) begin
    if (!reset) begin
      flag_f_r  <= 1'b0;
      flag_5s_r <= 1'b0;
      flag_c_r  <= 1'b0;
      fnum_r    <= 5'd0;
      irq       <= 1'b0;
    end else begin
      if (frame_tick) begin
        flag_f_r <= 1'b1;
      end else if (rd1_tick) begin
        flag_f_r <= 1'b0;
      end else begin
        flag_f_r <= flag_f_r;
      end
      if (coinc_tick) begin
        flag_c_r <= 1'b1;
      end else if (rd1_tick) begin
        flag_c_r <= 1'b0;
      end else begin
        flag_c_r <= flag_c_r;
      end
      if (fifth_tick) begin
        flag_5s_r <= 1'b1;
      end else if (rd1_tick) begin
        flag_5s_r <= 1'b0;
      end else begin
        flag_5s_r <= flag_5s_r;
      end
      // Sprite number follows the input until 5S freezes it.
      if (!flag_5s_r) begin
        fnum_r <= fifth_num;
      end else begin
        fnum_r <= fnum_r;
      end
      irq <= flag_f_r && ie;
    end
  end

endmodule

// File: tb/tb_vdp_rd_ifce.sv
// Directed bench for vdp_rd_ifce: pointer and fetch handshake, stale fetch
// handling, write path, status byte and interrupt, and reset during a fetch.
module tb_vdp_rd_ifce;

  logic        pxclk = 1'b0;
  logic        reset;
  logic        rd0_tick, rd1_tick, wr0_tick;
  logic [7:0]  din;
  logic        addr_set;
  logic [13:0] addr_val;
  logic        addr_rd;
  logic        vram_rd_req;
  logic [13:0] vram_rd_addr;
  logic        vram_rd_ack;
  logic [7:0]  vram_rd_data;
  logic        frame_tick, coinc_tick, fifth_tick;
  logic [4:0]  fifth_num;
  logic        ie;
  logic        irq;
  logic [7:0]  dout;
  logic [13:0] vram_addr;
  logic        latch_clr;

  int checks = 0;
  int errors = 0;

  vdp_rd_ifce dut (
    .pxclk(pxclk), .reset(reset),
    .rd0_tick(rd0_tick), .rd1_tick(rd1_tick), .wr0_tick(wr0_tick), .din(din),
    .addr_set(addr_set), .addr_val(addr_val), .addr_rd(addr_rd),
    .vram_rd_req(vram_rd_req), .vram_rd_addr(vram_rd_addr),
    .vram_rd_ack(vram_rd_ack), .vram_rd_data(vram_rd_data),
    .frame_tick(frame_tick), .coinc_tick(coinc_tick), .fifth_tick(fifth_tick),
    .fifth_num(fifth_num), .ie(ie), .irq(irq),
    .dout(dout), .vram_addr(vram_addr), .latch_clr(latch_clr)
  );

  always #20 pxclk = ~pxclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, land 1 time unit after it, then drop all strobes.
  task automatic tick();
    @(posedge pxclk);
    #1;
    rd0_tick = 1'b0; rd1_tick = 1'b0; wr0_tick = 1'b0;
    addr_set = 1'b0; addr_rd = 1'b0; vram_rd_ack = 1'b0;
    frame_tick = 1'b0; coinc_tick = 1'b0; fifth_tick = 1'b0;
  endtask

  task automatic ack(input logic [7:0] data);
    vram_rd_ack = 1'b1; vram_rd_data = data;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    rd0_tick = 1'b0; rd1_tick = 1'b0; wr0_tick = 1'b0; din = 8'h00;
    addr_set = 1'b0; addr_val = 14'h0000; addr_rd = 1'b0;
    vram_rd_ack = 1'b0; vram_rd_data = 8'h00;
    frame_tick = 1'b0; coinc_tick = 1'b0; fifth_tick = 1'b0;
    fifth_num = 5'd0; ie = 1'b0;
    #1;
    check("rst_req", 32'(vram_rd_req), 32'd0);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_addr", 32'(vram_addr), 32'h0000);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_latch", 32'(latch_clr), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    check("no_fetch_after_rst", 32'(vram_rd_req), 32'd0);

    // Read setup at 0x1234, ack three cycles later, then a data read.
    addr_set = 1'b1; addr_val = 14'h1234; addr_rd = 1'b1;
    tick();
    check("t32_req", 32'(vram_rd_req), 32'd1);
    check("t32_raddr", 32'(vram_rd_addr), 32'h1234);
    check("t32_ptr", 32'(vram_addr), 32'h1234);
    tick(); tick();
    check("t32_req_hold", 32'(vram_rd_req), 32'd1);
    ack(8'hA5);
    check("t32_req_drop", 32'(vram_rd_req), 32'd0);
    rd0_tick = 1'b1; tick();
    check("t32_dout", 32'(dout), 32'hA5);
    check("t32_ptr_inc", 32'(vram_addr), 32'h1235);
    check("t32_req2", 32'(vram_rd_req), 32'd1);
    check("t32_raddr2", 32'(vram_rd_addr), 32'h1235);
    check("t32_latch", 32'(latch_clr), 32'd1);

    // Data read while the fetch at 0x1235 is still outstanding.
    rd0_tick = 1'b1; tick();
    check("t34_dout", 32'(dout), 32'hA5);
    check("t34_ptr", 32'(vram_addr), 32'h1236);
    check("t34_raddr_held", 32'(vram_rd_addr), 32'h1235);
    check("t34_latch_on", 32'(latch_clr), 32'd1);
    tick();
    check("t34_latch_off", 32'(latch_clr), 32'd0);
    ack(8'h11);
    check("t34_idle", 32'(vram_rd_req), 32'd0);
    tick();
    check("t34_reissue", 32'(vram_rd_req), 32'd1);
    check("t34_reissue_addr", 32'(vram_rd_addr), 32'h1236);
    ack(8'h22);
    rd0_tick = 1'b1; tick();
    check("t34_discarded", 32'(dout), 32'h22);
    ack(8'h33);

    // Pointer wrap at 0x3FFF.
    addr_set = 1'b1; addr_val = 14'h3FFF; addr_rd = 1'b1;
    tick();
    check("t33_raddr", 32'(vram_rd_addr), 32'h3FFF);
    ack(8'h77);
    rd0_tick = 1'b1; tick();
    check("t33_dout1", 32'(dout), 32'h77);
    check("t33_wrap_ptr", 32'(vram_addr), 32'h0000);
    check("t33_wrap_raddr", 32'(vram_rd_addr), 32'h0000);
    ack(8'h88);
    rd0_tick = 1'b1; tick();
    check("t33_dout2", 32'(dout), 32'h88);
    check("t33_ptr", 32'(vram_addr), 32'h0001);
    ack(8'h44);

    // CPU write, then read back; then write during an outstanding fetch.
    wr0_tick = 1'b1; din = 8'h5A; tick();
    check("wr_ptr", 32'(vram_addr), 32'h0002);
    check("wr_no_fetch", 32'(vram_rd_req), 32'd0);
    check("wr_latch", 32'(latch_clr), 32'd1);
    rd0_tick = 1'b1; tick();
    check("wr_readback", 32'(dout), 32'h5A);
    check("wr_fetch_addr", 32'(vram_rd_addr), 32'h0003);
    wr0_tick = 1'b1; din = 8'h3C; tick();
    ack(8'h99);
    tick();
    check("wr_no_reissue", 32'(vram_rd_req), 32'd0);
    rd0_tick = 1'b1; tick();
    check("wr_stale_kept", 32'(dout), 32'h3C);
    check("wr_fetch_addr2", 32'(vram_rd_addr), 32'h0005);
    ack(8'h55);

    // addr_set (write setup) together with a data read.
    addr_set = 1'b1; addr_val = 14'h0100; addr_rd = 1'b0; rd0_tick = 1'b1;
    tick();
    check("t19_dout", 32'(dout), 32'h55);
    check("t19_ptr", 32'(vram_addr), 32'h0100);
    check("t19_raddr", 32'(vram_rd_addr), 32'h0100);
    check("t19_req", 32'(vram_rd_req), 32'd1);
    ack(8'h66);

    // Status: F, 5S with num 7 then 9, interrupt.
    ie = 1'b1;
    frame_tick = 1'b1; tick();
    fifth_tick = 1'b1; fifth_num = 5'd7; tick();
    fifth_tick = 1'b1; fifth_num = 5'd9; tick();
    fifth_num = 5'd3; tick();
    check("t35_irq", 32'(irq), 32'd1);
    rd1_tick = 1'b1; tick();
    check("t36_status", 32'(dout), 32'hC7);
    check("t36_latch", 32'(latch_clr), 32'd1);
    check("t36_irq_1cyc", 32'(irq), 32'd1);
    tick();
    check("t36_irq_clear", 32'(irq), 32'd0);

    // frame_tick coincident with rd1_tick.
    frame_tick = 1'b1; rd1_tick = 1'b1; tick();
    check("t37_pre_event", 32'(dout), 32'h03);
    rd1_tick = 1'b1; tick();
    check("t37_f_kept", 32'(dout), 32'h83);
    coinc_tick = 1'b1; tick();
    rd1_tick = 1'b1; tick();
    check("coinc_status", 32'(dout), 32'h23);
    tick(); tick();
    check("dout_hold", 32'(dout), 32'h23);
    ie = 1'b0; frame_tick = 1'b1; tick(); tick();
    check("irq_masked", 32'(irq), 32'd0);

    // Reset asserted while a fetch is outstanding.
    addr_set = 1'b1; addr_val = 14'h0200; addr_rd = 1'b1; tick();
    check("rst_mid_req_on", 32'(vram_rd_req), 32'd1);
    reset = 1'b0; #1;
    check("rst_mid_req_drop", 32'(vram_rd_req), 32'd0);
    check("rst_mid_ptr", 32'(vram_addr), 32'h0000);
    check("rst_mid_dout", 32'(dout), 32'h00);
    tick();
    reset = 1'b1;
    ack(8'hEE);
    check("late_ack_ignored", 32'(vram_rd_req), 32'd0);
    tick();
    check("late_no_fetch", 32'(vram_rd_req), 32'd0);
    rd0_tick = 1'b1; tick();
    check("late_buf_zero", 32'(dout), 32'h00);
    ack(8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
